uart_tx_io: RTL and testbench



---
 rtl/uart_io_pkg.sv | 41 ++++
 rtl/uart_tx_io_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_io.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_io.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS/CTRL bit positions.
package uart_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_ACTIVE  = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 4;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

  function automatic logic [15:0] pack_status(input logic empty,
                                              input logic full,
                                              input logic active,
                                              input logic ovf,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [15:0] s;
    s                              = '0;
    s[STAT_EMPTY]                  = empty;
    s[STAT_FULL]                   = full;
    s[STAT_ACTIVE]                 = active;
    s[STAT_OVF]                    = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W]  = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_io_sync_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and a registered-array
// head output. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_io.sv
// UART 8N1 transmitter peripheral on the CPU IO bus: register decode, TX FIFO
// and a baud-timed shifter driving a registered tx pin.
//
// state | meaning
// IDLE  | tx high, waiting for a byte in the FIFO
// START | start bit (tx low) for CLK_DIV cycles
// DATA  | 8 data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (tx high) for CLK_DIV cycles
module uart_tx_io
  import uart_io_pkg::*;
#(
  parameter int CLK_DIV    = 87,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_ctrl,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [1:0]  reg_off,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  tx_state_t   state, state_d;
  logic [BW-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
  logic          bit_end;

  logic          wr_en, push, ctrl_wr, flush, clr_ovf, overflow;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          shifter_active;
  logic          unused_wdata;

  assign wr_en    = uart_ctrl & io_write;
  assign push     = wr_en & (reg_off == REG_TXDATA);
  assign ctrl_wr  = wr_en & (reg_off == REG_CTRL);
  assign flush    = ctrl_wr & wdata[CTRL_FLUSH];
  assign clr_ovf  = ctrl_wr & wdata[CTRL_CLR_OVF];
  assign unused_wdata = ^wdata[15:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (wdata[7:0]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !flush) begin
      overflow <= 1'b1;
    end
  end

  assign shifter_active = (state != ST_IDLE);
  assign busy           = shifter_active | ~fifo_empty;
  assign bit_end        = (baud_cnt == BAUD_LAST);

  always_comb begin
    rdata = '0;
    if (uart_ctrl && io_read && reg_off == REG_STATUS) begin
      rdata = pack_status(fifo_empty, fifo_full, shifter_active, overflow,
                          STAT_CNT_W'(fifo_count));
    end
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the next-state view so the line changes on the
    // same edge that the state does.
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: a queue-level model predicts which bytes go out and on
// which edge each start bit falls; a serial monitor decodes tx and scores it.
module tb_uart_tx_io;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_ctrl = 1'b0;
  logic        io_write = 1'b0;
  logic        io_read = 1'b0;
  logic [1:0]  reg_off = 2'd0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] rdata;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_io #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_ctrl (uart_ctrl),
    .io_write  (io_write),
    .io_read   (io_read),
    .reg_off   (reg_off),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx        (tx),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] b;
    int         e;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  int         free_at = 0;
  int         last_pop = -1000;
  int         edge_n = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  function automatic bit m_active();
    return (edge_n >= last_pop) && (edge_n < last_pop + FRAME);
  endfunction

  function automatic bit m_busy();
    return m_active() || (mq.size() != 0);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  // Applies the bus rules to the inputs present for the coming edge.
  task automatic model_edge();
    int  c, sz;
    bit  wr;
    if (!rst) return;
    c  = edge_n + 1;
    sz = mq.size();
    wr = uart_ctrl && io_write;
    if (c >= free_at && sz > 0) begin
      exp_t e;
      e.b = mq.pop_front();
      e.e = c;
      sb.push_back(e);
      last_pop = c;
      free_at  = c + FRAME + 1;
    end
    if (wr && reg_off == 2'd2 && wdata[0]) m_ovf = 1'b0;
    if (wr && reg_off == 2'd2 && wdata[1]) begin
      mq.delete();
    end else if (wr && reg_off == 2'd0) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else mq.push_back(wdata[7:0]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    edge_n++;
    #1;
    check("busy", {15'h0, busy}, {15'h0, m_busy()});
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write(input logic [1:0] off, input logic [15:0] data);
    uart_ctrl = 1'b1; io_write = 1'b1; reg_off = off; wdata = data;
    tick();
    uart_ctrl = 1'b0; io_write = 1'b0; reg_off = 2'd0; wdata = 16'h0;
  endtask

  task automatic read_status(input string name);
    logic [15:0] e;
    e      = 16'h0;
    e[0]   = (mq.size() == 0);
    e[1]   = (mq.size() == DEPTH);
    e[2]   = m_active();
    e[3]   = m_ovf;
    e[7:4] = 4'(mq.size());
    uart_ctrl = 1'b1; io_read = 1'b1; reg_off = 2'd1;
    #1;
    check(name, rdata, e);
    uart_ctrl = 1'b0; io_read = 1'b0; reg_off = 2'd0;
  endtask

  task automatic read_zero(input string name, input logic ctrl, input logic [1:0] off);
    uart_ctrl = ctrl; io_read = 1'b1; reg_off = off;
    #1;
    check(name, rdata, 16'h0000);
    uart_ctrl = 1'b0; io_read = 1'b0; reg_off = 2'd0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((m_busy() || sb.size() != 0) && k < limit) begin
      tick();
      k++;
    end
    check("drain", {15'h0, (m_busy() || sb.size() != 0)}, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mq.delete(); sb.delete();
    m_ovf = 1'b0; free_at = 0; last_pop = -1000;
    uart_ctrl = 1'b1; io_read = 1'b1; reg_off = 2'd1;
    #1;
    check("rst_tx", {15'h0, tx}, 16'h1);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_status", rdata, 16'h0001);
    uart_ctrl = 1'b0; io_read = 1'b0; reg_off = 2'd0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Serial monitor: decodes each frame mid-bit and scores it against sb.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
        int         st;
        logic [7:0] got;
        bit         ok, start_ok;
        logic       stop;
        st = edge_n; got = 8'h0; ok = 1'b1; start_ok = 1'b1; stop = 1'b0;
        for (int k = 1; k <= 9 * DIV + DIV / 2; k++) begin
          @(negedge clk);
          if (!rst) begin ok = 1'b0; break; end
          if (k == DIV / 2 && tx !== 1'b0) start_ok = 1'b0;
          if (k >= DIV + DIV / 2 && k < 9 * DIV && ((k - DIV / 2) % DIV) == 0) begin
            int idx;
            idx = (k - DIV / 2) / DIV - 1;
            got[idx] = tx;
          end
          if (k == 9 * DIV + DIV / 2) stop = tx;
        end
        if (ok) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL frame: got unexpected byte %h at edge %0d, expected no frame", got, st);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (got !== e.b || st != e.e || !start_ok || stop !== 1'b1) begin
              n_fail++;
              $display("FAIL frame: got byte %h start %0d startbit_ok %0d stop %b, expected byte %h start %0d stop 1",
                       got, st, start_ok, stop, e.b, e.e);
            end
          end
        end
      end
    end
  end

  initial begin
    int e0;
    #2;
    do_reset();
    idle(3);
    read_status("idle_status");

    // single byte and busy fall time
    write(2'd0, 16'h0055);
    e0 = edge_n;
    while (edge_n < e0 + 40) tick();
    check("busy_e40", {15'h0, busy}, 16'h1);
    tick();
    check("busy_e41", {15'h0, busy}, 16'h0);
    check("tx_e41", {15'h0, tx}, 16'h1);
    drain(200);

    // overflow: ten back-to-back pushes
    idle(2);
    for (int i = 1; i <= 10; i++) write(2'd0, 16'(i));
    read_status("ovf_status");
    write(2'd2, 16'h0001);
    read_status("ovf_clear");
    drain(FRAME * 12);

    // back-to-back frames
    write(2'd0, 16'h00A3);
    write(2'd0, 16'h000F);
    drain(FRAME * 3);

    // flush during the first frame's data bits
    write(2'd0, 16'h0011);
    write(2'd0, 16'h0022);
    write(2'd0, 16'h0033);
    idle(2 * DIV);
    write(2'd2, 16'h0002);
    read_status("flush_mid");
    drain(FRAME * 3);
    read_status("flush_after");

    // read isolation and ignored writes
    write(2'd0, 16'h005A);
    idle(3);
    read_zero("rd_off0", 1'b1, 2'd0); tick();
    read_zero("rd_off2", 1'b1, 2'd2); tick();
    read_zero("rd_off3", 1'b1, 2'd3); tick();
    read_zero("rd_nosel", 1'b0, 2'd1); tick();
    write(2'd1, 16'hFFFF);
    write(2'd3, 16'h00FF);
    read_status("iso_status");
    drain(FRAME * 3);

    // asynchronous reset mid-frame
    write(2'd0, 16'h00C6);
    write(2'd0, 16'h0081);
    idle(3 * DIV);
    do_reset();
    idle(5);
    read_status("post_rst");

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) write(2'd0, 16'($urandom));
      else if (r == 6) write(2'd2, 16'($urandom_range(0, 3)));
      else if (r == 7) begin read_status("rand_status"); tick(); end
      else idle($urandom_range(1, DIV * 12));
    end
    drain(FRAME * (DEPTH + 4));
    read_status("final_status");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
